// File: rtl/mpsk_pkg.sv
// Shared definitions for the M-PSK modulator: mode encodings, Gray-to-phase
// mapping and the quarter-wave sine constants used to build the sample ROM.
package mpsk_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK = 2'd0,
    MODE_QPSK = 2'd1,
    MODE_8PSK = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int ROM_DEPTH = 32;
  localparam int ROM_AW    = 5;
  localparam int SIN_FRAC  = 24;

  // The reserved encoding falls back to QPSK.
  function automatic logic [1:0] bps_of(input logic [1:0] mode);
    case (mode_e'(mode))
      MODE_BPSK: bps_of = 2'd1;
      MODE_8PSK: bps_of = 2'd3;
      default:   bps_of = 2'd2;
    endcase
  endfunction

  // Phase index in 45 degree steps; only the low bps bits of sym are used.
  function automatic logic [2:0] gray_to_phase(input logic [2:0] sym, input logic [1:0] bps);
    logic [2:0] p;
    p = 3'd0;
    case (bps)
      2'd1: p = sym[0] ? 3'd4 : 3'd0;
      2'd3: begin
        case (sym)
          3'b000: p = 3'd0;
          3'b001: p = 3'd1;
          3'b011: p = 3'd2;
          3'b010: p = 3'd3;
          3'b110: p = 3'd4;
          3'b111: p = 3'd5;
          3'b101: p = 3'd6;
          default: p = 3'd7;
        endcase
      end
      default: begin
        case (sym[1:0])
          2'b00: p = 3'd0;
          2'b01: p = 3'd2;
          2'b11: p = 3'd4;
          default: p = 3'd6;
        endcase
      end
    endcase
    return p;
  endfunction

  // sin(j * 11.25 deg) in Q0.24 for j = 0..8 (first quadrant, inclusive).
  function automatic longint sin_q24(input int j);
    case (j)
      0: sin_q24 = 64'sd0;
      1: sin_q24 = 64'sd3273072;
      2: sin_q24 = 64'sd6420363;
      3: sin_q24 = 64'sd9320922;
      4: sin_q24 = 64'sd11863283;
      5: sin_q24 = 64'sd13949745;
      6: sin_q24 = 64'sd15500126;
      7: sin_q24 = 64'sd16454847;
      default: sin_q24 = 64'sd16777216;
    endcase
  endfunction

endpackage

// File: rtl/mpsk_sine_rom.sv
// Registered 32-entry offset-binary sine lookup; the table is folded out of
// the first-quadrant constants at elaboration for any DATA_W.
module mpsk_sine_rom
  import mpsk_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ROM_AW-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  // Quadrant folding keeps rounding symmetric about midscale.
  function automatic logic [DATA_W-1:0] sine_val(input int i);
    int     quadrant;
    int     q;
    int     j;
    longint amp;
    longint mag;
    longint val;
    quadrant = i / 8;
    q        = i % 8;
    j        = (quadrant % 2 == 1) ? (8 - q) : q;
    amp      = (longint'(1) << (DATA_W - 1)) - 1;
    mag      = (amp * sin_q24(j) + (longint'(1) << (SIN_FRAC - 1))) >>> SIN_FRAC;
    val      = (longint'(1) << (DATA_W - 1));
    val      = (quadrant >= 2) ? (val - mag) : (val + mag);
    return DATA_W'(val);
  endfunction

  logic [DATA_W-1:0] table_mem [ROM_DEPTH];

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    localparam logic [DATA_W-1:0] ENTRY = sine_val(i);
    assign table_mem[i] = ENTRY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= MID;
    end else if (en) begin
      data <= table_mem[addr];
    end
  end

endmodule

// File: rtl/mpsk_modulator.sv
// Serial-bit M-PSK modulator: collects BPSK/QPSK/8PSK symbols into a
// one-deep holding register and plays them out as paced carrier samples.
module mpsk_modulator
  import mpsk_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int SPS    = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [1:0]        mode,
  input  logic              Din,
  input  logic              Din_valid,
  output logic              Din_ready,
  input  logic              sample_en,
  output logic [DATA_W-1:0] Sout,
  output logic              Sout_valid,
  output logic              sym_strobe,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int           K_W    = $clog2(SPS);
  localparam int           STEP   = ROM_DEPTH / SPS;
  localparam logic [K_W-1:0] K_LAST = K_W'(SPS - 1);

  logic [1:0]        col_bps;
  logic [1:0]        bit_cnt;
  logic [1:0]        col_sr;
  logic              hold_full;
  logic [2:0]        hold_phase;
  logic [2:0]        cur_phase;
  logic [K_W-1:0]    k;
  logic              started;

  logic [1:0]        eff_bps;
  logic              accept;
  logic              complete;
  logic [2:0]        shift_in;
  logic              boundary;
  logic [2:0]        next_phase;
  logic [2:0]        sample_phase;
  logic [ROM_AW-1:0] k_offset;
  logic [ROM_AW-1:0] rom_addr;

  // Mode is only sampled at a symbol start, so a change mid-symbol waits for the next one.
  always_comb begin
    eff_bps      = (bit_cnt == 2'd0) ? bps_of(mode) : col_bps;
    Din_ready    = !hold_full || (bit_cnt != eff_bps - 2'd1);
    accept       = Din_valid && Din_ready;
    complete     = accept && (bit_cnt == eff_bps - 2'd1);
    shift_in     = (bit_cnt == 2'd0) ? {2'b00, Din} : {col_sr, Din};
    boundary     = sample_en && (!started || k == K_LAST);
    next_phase   = hold_full ? hold_phase : 3'd0;
    sample_phase = (boundary && !started) ? next_phase : cur_phase;
    k_offset     = ROM_AW'(int'(k) * STEP);
    rom_addr     = k_offset + {sample_phase, 2'b00};
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      col_bps <= 2'd2;
      bit_cnt <= 2'd0;
      col_sr  <= 2'd0;
    end else if (accept) begin
      col_sr <= shift_in[1:0];
      if (bit_cnt == 2'd0) begin
        col_bps <= bps_of(mode);
      end
      bit_cnt <= complete ? 2'd0 : bit_cnt + 2'd1;
    end
  end

  // A completion wins over a consume so a freshly finished symbol is never lost.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hold_full  <= 1'b0;
      hold_phase <= 3'd0;
    end else if (complete) begin
      hold_full  <= 1'b1;
      hold_phase <= gray_to_phase(shift_in, eff_bps);
    end else if (boundary) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cur_phase <= 3'd0;
      k         <= '0;
      started   <= 1'b0;
    end else if (sample_en) begin
      if (boundary) begin
        cur_phase <= next_phase;
      end
      k       <= (k == K_LAST) ? '0 : k + 1'b1;
      started <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Sout_valid <= 1'b0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      Sout_valid <= sample_en;
      sym_strobe <= sample_en && (k == '0);
      if (underrun_clr) begin
        underrun <= 1'b0;
      end else if (boundary && !hold_full) begin
        underrun <= 1'b1;
      end
    end
  end

  mpsk_sine_rom #(
    .DATA_W(DATA_W)
  ) u_rom (
    .clk  (CLK),
    .rst_n(RSTn),
    .en   (sample_en),
    .addr (rom_addr),
    .data (Sout)
  );

endmodule

// File: tb/tb_mpsk_modulator.sv
// Bench for mpsk_modulator: directed vector table, multi-cycle corner
// sequences and a randomized run against a behavioural symbol/sample model.
module tb_mpsk_modulator;

  localparam int DATA_W = 12;
  localparam int SPS    = 8;
  localparam int MID    = 2048;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              Din = 1'b0;
  logic              Din_valid = 1'b0;
  logic              Din_ready;
  logic              sample_en = 1'b0;
  logic [DATA_W-1:0] Sout;
  logic              Sout_valid;
  logic              sym_strobe;
  logic              underrun;
  logic              underrun_clr = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mpsk_modulator #(
    .DATA_W(DATA_W),
    .SPS   (SPS)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .mode        (mode),
    .Din         (Din),
    .Din_valid   (Din_valid),
    .Din_ready   (Din_ready),
    .sample_en   (sample_en),
    .Sout        (Sout),
    .Sout_valid  (Sout_valid),
    .sym_strobe  (sym_strobe),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Offset-binary sample straight from the sine definition.
  function automatic int sine_ref(input int idx);
    real amp;
    real v;
    int  r;
    amp = (2.0 ** (DATA_W - 1)) - 1.0;
    v   = amp * $sin(2.0 * 3.14159265358979 * idx / 32.0);
    r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    return MID + r;
  endfunction

  // The symbol is the Gray code of its phase position q; step is 8/(2^bps).
  function automatic int gray_phase(input int bits, input int bps);
    for (int q = 0; q < (1 << bps); q++) begin
      if ((q ^ (q >> 1)) == bits) return q << (3 - bps);
    end
    return 0;
  endfunction

  int m_q[$];
  int m_cur, m_k, m_bps, m_cnt, m_bits;
  bit m_started, m_under;
  int exp_sout;
  bit exp_valid, exp_strobe, exp_under;

  always @(negedge CLK) begin : model
    int  ph;
    int  nxt;
    bit  bnd;
    if (!RSTn) begin
      m_q.delete();
      m_cur = 0; m_k = 0; m_bps = 2; m_cnt = 0; m_bits = 0;
      m_started = 0; m_under = 0;
      exp_sout = MID; exp_valid = 0; exp_strobe = 0; exp_under = 0;
    end else begin
      checkOutput("model_sout", 32'(Sout), exp_sout);
      checkOutput("model_valid", 32'(Sout_valid), 32'(exp_valid));
      checkOutput("model_strobe", 32'(sym_strobe), 32'(exp_strobe));
      checkOutput("model_underrun", 32'(underrun), 32'(exp_under));
      exp_valid  = sample_en;
      exp_strobe = sample_en && (m_k == 0);
      if (sample_en) begin
        bnd = !m_started || (m_k == SPS - 1);
        ph  = m_cur;
        if (bnd) begin
          if (m_q.size() > 0) begin
            nxt = m_q.pop_front();
          end else begin
            nxt = 0;
            m_under = 1;
          end
          if (!m_started) ph = nxt;
          m_cur = nxt;
        end
        exp_sout  = sine_ref((m_k * (32 / SPS) + ph * 4) % 32);
        m_k       = (m_k + 1) % SPS;
        m_started = 1;
      end
      if (underrun_clr) m_under = 0;
      exp_under = m_under;
      if (Din_valid && Din_ready) begin
        if (m_cnt == 0) begin
          m_bps  = (mode == 2'd0) ? 1 : (mode == 2'd2) ? 3 : 2;
          m_bits = 0;
        end
        m_bits = m_bits * 2 + int'(Din);
        m_cnt++;
        if (m_cnt == m_bps) begin
          m_q.push_back(gray_phase(m_bits, m_bps));
          m_cnt = 0;
        end
      end
    end
  end

  int rec_q[$];
  bit str_q[$];

  always @(negedge CLK) begin
    if (RSTn && Sout_valid) begin
      rec_q.push_back(int'(Sout));
      str_q.push_back(sym_strobe);
    end
  end

  task automatic applyStimulus(input bit se, input bit dv, input bit d, input bit clr);
    sample_en    = se;
    Din_valid    = dv;
    Din          = d;
    underrun_clr = clr;
    @(posedge CLK); #2;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    sample_en = 1'b0; Din_valid = 1'b0; underrun_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RSTn = 1'b1;
  endtask

  task automatic send_bit(input bit b);
    bit ok;
    ok = 0;
    Din = b;
    Din_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge CLK);
      if (Din_ready) ok = 1;
      @(posedge CLK); #2;
    end
    Din_valid = 1'b0;
    checkOutput("bit_accept", 32'(ok), 32'd1);
  endtask

  task automatic pulse_samples(input int n);
    for (int i = 0; i < n; i++) begin
      sample_en = 1'b1;
      @(posedge CLK); #2;
    end
    sample_en = 1'b0;
    @(negedge CLK); #1;
    @(posedge CLK); #2;
  endtask

  typedef struct {
    logic [1:0] mode;
    int nbits;
    int bits;
    int e0, e1, e2, e3;
  } vec_t;

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin : main
    vec_t vecs[8];
    int   exp16[16];

    vecs[0] = '{2'd0, 1, 3'b0,   2048, 3495, 4095, 3495};
    vecs[1] = '{2'd0, 1, 3'b1,   2048,  601,    1,  601};
    vecs[2] = '{2'd1, 2, 3'b11,  2048,  601,    1,  601};
    vecs[3] = '{2'd1, 2, 3'b01,  4095, 3495, 2048,  601};
    vecs[4] = '{2'd2, 3, 3'b010, 3495, 2048,  601,    1};
    vecs[5] = '{2'd3, 2, 3'b10,     1,  601, 2048, 3495};
    vecs[6] = '{2'd2, 3, 3'b111,  601,    1,  601, 2048};
    vecs[7] = '{2'd2, 3, 3'b100,  601, 2048, 3495, 4095};
    exp16 = '{2048, 3495, 4095, 3495, 2048, 601, 1, 601,
              2048, 601, 1, 601, 2048, 3495, 4095, 3495};

    @(posedge CLK); #2;
    do_reset();
    @(negedge CLK);
    checkOutput("rst_sout", 32'(Sout), MID);
    checkOutput("rst_valid", 32'(Sout_valid), 0);
    checkOutput("rst_underrun", 32'(underrun), 0);
    checkOutput("rst_ready", 32'(Din_ready), 1);
    @(posedge CLK); #2;

    for (int v = 0; v < 8; v++) begin
      do_reset();
      mode = vecs[v].mode;
      for (int j = vecs[v].nbits - 1; j >= 0; j--) send_bit(bit'((vecs[v].bits >> j) & 1));
      rec_q.delete(); str_q.delete();
      pulse_samples(4);
      checkOutput($sformatf("vec%0d_count", v), 32'(rec_q.size()), 4);
      if (rec_q.size() == 4) begin
        checkOutput($sformatf("vec%0d_s0", v), rec_q[0], vecs[v].e0);
        checkOutput($sformatf("vec%0d_s1", v), rec_q[1], vecs[v].e1);
        checkOutput($sformatf("vec%0d_s2", v), rec_q[2], vecs[v].e2);
        checkOutput($sformatf("vec%0d_s3", v), rec_q[3], vecs[v].e3);
        checkOutput($sformatf("vec%0d_strobe0", v), 32'(str_q[0]), 1);
        checkOutput($sformatf("vec%0d_strobe1", v), 32'(str_q[1]), 0);
      end
      checkOutput($sformatf("vec%0d_underrun", v), 32'(underrun), 0);
    end

    // BPSK bits 0 then 1 over 16 continuous samples.
    do_reset();
    mode = 2'd0;
    send_bit(1'b0);
    rec_q.delete(); str_q.delete();
    fork
      pulse_samples(16);
      send_bit(1'b1);
    join
    checkOutput("bpsk_count", 32'(rec_q.size()), 16);
    if (rec_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checkOutput($sformatf("bpsk_s%0d", i), rec_q[i], exp16[i]);
        checkOutput($sformatf("bpsk_strobe%0d", i), 32'(str_q[i]), (i % 8 == 0) ? 1 : 0);
      end
    end

    // Backpressure, then underrun and its clear.
    do_reset();
    mode = 2'd1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    @(negedge CLK);
    checkOutput("bp_ready_blocked", 32'(Din_ready), 0);
    @(posedge CLK); #2;
    rec_q.delete(); str_q.delete();
    sample_en = 1'b1;
    @(negedge CLK);
    checkOutput("bp_ready_before_consume", 32'(Din_ready), 0);
    @(posedge CLK); #2;
    @(negedge CLK);
    checkOutput("bp_ready_after_consume", 32'(Din_ready), 1);
    @(posedge CLK); #2;
    fork
      pulse_samples(18);
      send_bit(1'b1);
    join
    checkOutput("bp_count", 32'(rec_q.size()), 20);
    if (rec_q.size() == 20) begin
      checkOutput("bp_sym0_s0", rec_q[0], 1);
      checkOutput("bp_sym0_s2", rec_q[2], 2048);
      checkOutput("bp_sym1_s0", rec_q[8], 4095);
      checkOutput("bp_sym1_s1", rec_q[9], 3495);
      checkOutput("bp_under_s0", rec_q[16], 2048);
      checkOutput("bp_under_s1", rec_q[17], 3495);
      checkOutput("bp_under_s2", rec_q[18], 4095);
      checkOutput("bp_strobe8", 32'(str_q[8]), 1);
      checkOutput("bp_strobe16", 32'(str_q[16]), 1);
    end
    checkOutput("underrun_set", 32'(underrun), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("underrun_cleared", 32'(underrun), 0);

    // Mode change mid-collection.
    do_reset();
    mode = 2'd1;
    send_bit(1'b1);
    mode = 2'd2;
    send_bit(1'b1);
    rec_q.delete(); str_q.delete();
    pulse_samples(1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    pulse_samples(8);
    checkOutput("mc_count", 32'(rec_q.size()), 9);
    if (rec_q.size() == 9) begin
      checkOutput("mc_qpsk_s0", rec_q[0], 2048);
      checkOutput("mc_qpsk_s1", rec_q[1], 601);
      checkOutput("mc_8psk_s0", rec_q[8], 3495);
      checkOutput("mc_8psk_strobe", 32'(str_q[8]), 1);
    end
    checkOutput("mc_underrun", 32'(underrun), 0);

    // Randomized traffic in segments of differing input density.
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
        applyStimulus(bit'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) < (seg % 3) * 4 + 1),
                      bit'($urandom_range(0, 1)),
                      ($urandom_range(0, 39) == 0));
      end
    end

    // Asynchronous reset while traffic is live.
    sample_en = 1'b1;
    Din_valid = 1'b1;
    RSTn = 1'b0;
    #1;
    checkOutput("async_rst_sout", 32'(Sout), MID);
    checkOutput("async_rst_valid", 32'(Sout_valid), 0);
    checkOutput("async_rst_underrun", 32'(underrun), 0);
    checkOutput("async_rst_ready", 32'(Din_ready), 1);
    do_reset();
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
